// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: default sizing, entry layout
// and the tag <-> entry index mapping (tag = index + 1, tag 0 means "no tag").
package reorder_buffer_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_TAG_W  = 5;
  localparam int ROB_DATA_W = 32;
  localparam int ROB_REG_W  = 5;
  localparam int NULL_TAG   = 0;

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic                  we;
    logic [ROB_REG_W-1:0]  rd;
    logic [ROB_DATA_W-1:0] value;
  } rob_entry_t;

  function automatic int tag_to_idx(input int tag);
    return tag - 1;
  endfunction

  function automatic int idx_to_tag(input int idx);
    return idx + 1;
  endfunction

endpackage

// File: rtl/reorder_buffer_lookup.sv
// Combinational operand read for one source tag: same-cycle writeback
// bypass first (port 1 over port 2), then completed entries in the buffer.
module rob_lookup
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int TAG_W  = ROB_TAG_W,
  parameter int DATA_W = ROB_DATA_W
) (
  input  logic [TAG_W-1:0]  tag,
  input  logic              wb_valid1,
  input  logic [TAG_W-1:0]  wb_tag1,
  input  logic [DATA_W-1:0] wb_data1,
  input  logic              wb_valid2,
  input  logic [TAG_W-1:0]  wb_tag2,
  input  logic [DATA_W-1:0] wb_data2,
  input  logic [DEPTH-1:0]  busy,
  input  logic [DEPTH-1:0]  done,
  input  logic [DATA_W-1:0] values [DEPTH],
  output logic              ready,
  output logic [DATA_W-1:0] value
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDX_W-1:0] idx;
  logic             is_null;
  logic             in_range;

  // Tag 0 maps to an all-ones index; it is never used because is_null wins.
  assign idx      = IDX_W'(tag_to_idx(int'(tag)));
  assign is_null  = (tag == TAG_W'(NULL_TAG));
  assign in_range = (tag <= TAG_W'(DEPTH));

  always_comb begin
    ready = 1'b0;
    value = '0;
    if (is_null) begin
      ready = 1'b0;
      value = '0;
    end else if (wb_valid1 && (wb_tag1 == tag)) begin
      ready = 1'b1;
      value = wb_data1;
    end else if (wb_valid2 && (wb_tag2 == tag)) begin
      ready = 1'b1;
      value = wb_data2;
    end else if (in_range && busy[idx] && done[idx]) begin
      ready = 1'b1;
      value = values[idx];
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: tag allocation, dual writeback, operand forwarding
// and up to two in-order retirements per cycle. Entry fields use package widths.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int TAG_W  = ROB_TAG_W,
  parameter int DATA_W = ROB_DATA_W,
  parameter int REG_W  = ROB_REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc,
  input  logic [REG_W-1:0]  alloc_rd,
  input  logic              alloc_we,
  output logic [TAG_W-1:0]  alloc_tag,
  output logic              full,
  output logic [TAG_W-1:0]  count,
  input  logic              wb_valid1,
  input  logic              wb_valid2,
  input  logic [TAG_W-1:0]  wb_tag1,
  input  logic [TAG_W-1:0]  wb_tag2,
  input  logic [DATA_W-1:0] wb_data1,
  input  logic [DATA_W-1:0] wb_data2,
  input  logic [TAG_W-1:0]  src1_tag,
  input  logic [TAG_W-1:0]  src2_tag,
  output logic              src1_ready,
  output logic              src2_ready,
  output logic [DATA_W-1:0] src1_value,
  output logic [DATA_W-1:0] src2_value,
  input  logic              flush,
  output logic              commit_valid1,
  output logic              commit_valid2,
  output logic [REG_W-1:0]  commit_rd1,
  output logic [REG_W-1:0]  commit_rd2,
  output logic              commit_we1,
  output logic              commit_we2,
  output logic [DATA_W-1:0] commit_data1,
  output logic [DATA_W-1:0] commit_data2
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rob_entry_t        rob_q [DEPTH];
  rob_entry_t        rob_d [DEPTH];
  logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d, head_nxt;
  logic [TAG_W-1:0]  count_q, count_d;

  logic              cv1_q, cv1_d, cv2_q, cv2_d;
  logic              cwe1_q, cwe1_d, cwe2_q, cwe2_d;
  logic [REG_W-1:0]  crd1_q, crd1_d, crd2_q, crd2_d;
  logic [DATA_W-1:0] cdata1_q, cdata1_d, cdata2_q, cdata2_d;

  logic [DEPTH-1:0]  busy_vec, done_vec, wb1_sel, wb2_sel;
  logic [DATA_W-1:0] value_arr [DEPTH];
  logic              alloc_ok, commit1, commit2;

  // A writeback only lands on an entry that is currently allocated.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [TAG_W-1:0] ENTRY_TAG = TAG_W'(idx_to_tag(gi));
      assign busy_vec[gi]  = rob_q[gi].busy;
      assign done_vec[gi]  = rob_q[gi].done;
      assign value_arr[gi] = rob_q[gi].value;
      assign wb1_sel[gi]   = wb_valid1 && (wb_tag1 == ENTRY_TAG) && rob_q[gi].busy;
      assign wb2_sel[gi]   = wb_valid2 && (wb_tag2 == ENTRY_TAG) && rob_q[gi].busy;
    end
  endgenerate

  assign full      = (count_q == TAG_W'(DEPTH));
  assign count     = count_q;
  assign alloc_tag = TAG_W'(idx_to_tag(int'(tail_q)));
  assign alloc_ok  = alloc && !full;
  assign head_nxt  = head_q + IDX_W'(1);
  assign commit1   = rob_q[head_q].busy && rob_q[head_q].done;
  assign commit2   = commit1 && rob_q[head_nxt].busy && rob_q[head_nxt].done;

  always_comb begin
    rob_d    = rob_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    cv1_d    = 1'b0;
    cv2_d    = 1'b0;
    cwe1_d   = 1'b0;
    cwe2_d   = 1'b0;
    crd1_d   = '0;
    crd2_d   = '0;
    cdata1_d = '0;
    cdata2_d = '0;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob_d[i].busy = 1'b0;
        rob_d[i].done = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Port 2 first so that port 1 overwrites it on a shared tag.
      for (int i = 0; i < DEPTH; i++) begin
        if (wb2_sel[i]) begin
          rob_d[i].done  = 1'b1;
          rob_d[i].value = wb_data2;
        end
        if (wb1_sel[i]) begin
          rob_d[i].done  = 1'b1;
          rob_d[i].value = wb_data1;
        end
      end
      if (commit1) begin
        cv1_d               = 1'b1;
        crd1_d              = rob_q[head_q].rd;
        cwe1_d              = rob_q[head_q].we;
        cdata1_d            = rob_q[head_q].value;
        rob_d[head_q].busy  = 1'b0;
        rob_d[head_q].done  = 1'b0;
      end
      if (commit2) begin
        cv2_d                 = 1'b1;
        crd2_d                = rob_q[head_nxt].rd;
        cwe2_d                = rob_q[head_nxt].we;
        cdata2_d              = rob_q[head_nxt].value;
        rob_d[head_nxt].busy  = 1'b0;
        rob_d[head_nxt].done  = 1'b0;
      end
      // The tail slot is never busy when alloc_ok, so it cannot collide with a retiring head.
      if (alloc_ok) begin
        rob_d[tail_q].busy = 1'b1;
        rob_d[tail_q].done = 1'b0;
        rob_d[tail_q].rd   = alloc_rd;
        rob_d[tail_q].we   = alloc_we;
        tail_d             = tail_q + IDX_W'(1);
      end
      head_d  = commit2 ? (head_q + IDX_W'(2)) : (commit1 ? head_nxt : head_q);
      count_d = count_q + TAG_W'(alloc_ok) - TAG_W'(commit1) - TAG_W'(commit2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i] <= '0;
      end
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      cv1_q    <= 1'b0;
      cv2_q    <= 1'b0;
      cwe1_q   <= 1'b0;
      cwe2_q   <= 1'b0;
      crd1_q   <= '0;
      crd2_q   <= '0;
      cdata1_q <= '0;
      cdata2_q <= '0;
    end else begin
      rob_q    <= rob_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      cv1_q    <= cv1_d;
      cv2_q    <= cv2_d;
      cwe1_q   <= cwe1_d;
      cwe2_q   <= cwe2_d;
      crd1_q   <= crd1_d;
      crd2_q   <= crd2_d;
      cdata1_q <= cdata1_d;
      cdata2_q <= cdata2_d;
    end
  end

  assign commit_valid1 = cv1_q;
  assign commit_valid2 = cv2_q;
  assign commit_we1    = cwe1_q;
  assign commit_we2    = cwe2_q;
  assign commit_rd1    = crd1_q;
  assign commit_rd2    = crd2_q;
  assign commit_data1  = cdata1_q;
  assign commit_data2  = cdata2_q;

  rob_lookup #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_lookup1 (
    .tag(src1_tag), .wb_valid1(wb_valid1), .wb_tag1(wb_tag1), .wb_data1(wb_data1),
    .wb_valid2(wb_valid2), .wb_tag2(wb_tag2), .wb_data2(wb_data2),
    .busy(busy_vec), .done(done_vec), .values(value_arr),
    .ready(src1_ready), .value(src1_value)
  );

  rob_lookup #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_lookup2 (
    .tag(src2_tag), .wb_valid1(wb_valid1), .wb_tag1(wb_tag1), .wb_data1(wb_data1),
    .wb_valid2(wb_valid2), .wb_tag2(wb_tag2), .wb_data2(wb_data2),
    .busy(busy_vec), .done(done_vec), .values(value_arr),
    .ready(src2_ready), .value(src2_value)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus randomized traffic checked
// against a queue-based program-order model of the buffer.
module tb_reorder_buffer;

  localparam int DEPTH  = 16;
  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              alloc, alloc_we, flush;
  logic [REG_W-1:0]  alloc_rd;
  logic [TAG_W-1:0]  alloc_tag, count;
  logic              full;
  logic              wb_valid1, wb_valid2;
  logic [TAG_W-1:0]  wb_tag1, wb_tag2, src1_tag, src2_tag;
  logic [DATA_W-1:0] wb_data1, wb_data2, src1_value, src2_value;
  logic              src1_ready, src2_ready;
  logic              commit_valid1, commit_valid2, commit_we1, commit_we2;
  logic [REG_W-1:0]  commit_rd1, commit_rd2;
  logic [DATA_W-1:0] commit_data1, commit_data2;

  always #5 clk = ~clk;

  reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .alloc(alloc), .alloc_rd(alloc_rd), .alloc_we(alloc_we),
    .alloc_tag(alloc_tag), .full(full), .count(count),
    .wb_valid1(wb_valid1), .wb_valid2(wb_valid2), .wb_tag1(wb_tag1), .wb_tag2(wb_tag2),
    .wb_data1(wb_data1), .wb_data2(wb_data2),
    .src1_tag(src1_tag), .src2_tag(src2_tag), .src1_ready(src1_ready), .src2_ready(src2_ready),
    .src1_value(src1_value), .src2_value(src2_value), .flush(flush),
    .commit_valid1(commit_valid1), .commit_valid2(commit_valid2),
    .commit_rd1(commit_rd1), .commit_rd2(commit_rd2),
    .commit_we1(commit_we1), .commit_we2(commit_we2),
    .commit_data1(commit_data1), .commit_data2(commit_data2)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: per-tag state plus the program-order list of live tags.
  bit                m_busy [DEPTH+1];
  bit                m_done [DEPTH+1];
  bit                m_we   [DEPTH+1];
  logic [REG_W-1:0]  m_rd   [DEPTH+1];
  logic [DATA_W-1:0] m_val  [DEPTH+1];
  int                m_order [$];
  int                m_next_tag;
  logic              e_cv1, e_cv2, e_we1, e_we2;
  logic [REG_W-1:0]  e_rd1, e_rd2;
  logic [DATA_W-1:0] e_d1, e_d2;

  task automatic model_clear(input bit wipe);
    for (int i = 0; i <= DEPTH; i++) begin
      m_busy[i] = 1'b0;
      m_done[i] = 1'b0;
      if (wipe) begin
        m_we[i] = 1'b0; m_rd[i] = '0; m_val[i] = '0;
      end
    end
    m_order.delete();
    m_next_tag = 1;
    e_cv1 = 1'b0; e_cv2 = 1'b0; e_we1 = 1'b0; e_we2 = 1'b0;
    e_rd1 = '0; e_rd2 = '0; e_d1 = '0; e_d2 = '0;
  endtask

  function automatic void model_src(input int tag, output logic rdy, output logic [DATA_W-1:0] val);
    rdy = 1'b0;
    val = '0;
    if (tag == 0) return;
    if (wb_valid1 && int'(wb_tag1) == tag) begin rdy = 1'b1; val = wb_data1; end
    else if (wb_valid2 && int'(wb_tag2) == tag) begin rdy = 1'b1; val = wb_data2; end
    else if (tag <= DEPTH && m_busy[tag] && m_done[tag]) begin rdy = 1'b1; val = m_val[tag]; end
  endfunction

  // Advance the model across one clock edge with the currently driven inputs.
  task automatic tick();
    int t1, t2, w1, w2;
    bit c1, c2, acc, ok1, ok2;
    c1 = 1'b0; c2 = 1'b0; t1 = 0; t2 = 0;
    e_cv1 = 1'b0; e_cv2 = 1'b0; e_we1 = 1'b0; e_we2 = 1'b0;
    e_rd1 = '0; e_rd2 = '0; e_d1 = '0; e_d2 = '0;
    if (flush) begin
      model_clear(1'b0);
    end else begin
      if (m_order.size() > 0 && m_done[m_order[0]]) begin c1 = 1'b1; t1 = m_order[0]; end
      if (c1 && m_order.size() > 1 && m_done[m_order[1]]) begin c2 = 1'b1; t2 = m_order[1]; end
      acc = alloc && (m_order.size() < DEPTH);
      w1  = int'(wb_tag1);
      w2  = int'(wb_tag2);
      ok1 = wb_valid1 && w1 >= 1 && w1 <= DEPTH && m_busy[w1];
      ok2 = wb_valid2 && w2 >= 1 && w2 <= DEPTH && m_busy[w2];
      if (c1) begin e_cv1 = 1'b1; e_rd1 = m_rd[t1]; e_we1 = m_we[t1]; e_d1 = m_val[t1]; end
      if (c2) begin e_cv2 = 1'b1; e_rd2 = m_rd[t2]; e_we2 = m_we[t2]; e_d2 = m_val[t2]; end
      if (ok2) begin m_done[w2] = 1'b1; m_val[w2] = wb_data2; end
      if (ok1) begin m_done[w1] = 1'b1; m_val[w1] = wb_data1; end
      if (c1) begin void'(m_order.pop_front()); m_busy[t1] = 1'b0; m_done[t1] = 1'b0; end
      if (c2) begin void'(m_order.pop_front()); m_busy[t2] = 1'b0; m_done[t2] = 1'b0; end
      if (acc) begin
        m_order.push_back(m_next_tag);
        m_busy[m_next_tag] = 1'b1;
        m_done[m_next_tag] = 1'b0;
        m_rd[m_next_tag]   = alloc_rd;
        m_we[m_next_tag]   = alloc_we;
        m_next_tag = (m_next_tag == DEPTH) ? 1 : m_next_tag + 1;
      end
    end
    @(posedge clk);
    #1;
    if (e_cv1) $display("[TB] t=%0t retire slot1 rd=%0d we=%0d data=%h", $time, e_rd1, e_we1, e_d1);
    if (e_cv2) $display("[TB] t=%0t retire slot2 rd=%0d we=%0d data=%h", $time, e_rd2, e_we2, e_d2);
  endtask

  task automatic drive_idle();
    alloc = 1'b0; alloc_rd = '0; alloc_we = 1'b0; flush = 1'b0;
    wb_valid1 = 1'b0; wb_tag1 = '0; wb_data1 = '0;
    wb_valid2 = 1'b0; wb_tag2 = '0; wb_data2 = '0;
    src1_tag = '0; src2_tag = '0;
  endtask

  task automatic do_flush();
    drive_idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    drive_idle();
    rst = 1'b1;
    src1_tag = 5'd1;
    model_clear(1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    tests++; if (count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", full); end
    tests++; if (alloc_tag !== 5'd1) begin fails++; $display("FAIL reset_alloc_tag: got %0d want 1", alloc_tag); end
    tests++; if (commit_valid1 !== 1'b0 || commit_valid2 !== 1'b0) begin fails++; $display("FAIL reset_commit_valid: got %b%b want 00", commit_valid1, commit_valid2); end
    tests++; if (src1_ready !== 1'b0) begin fails++; $display("FAIL reset_src1_ready: got %b want 0", src1_ready); end
  endtask

  task automatic test_commit_pair();
    $display("[TB] test_commit_pair");
    do_flush();
    alloc = 1'b1; alloc_we = 1'b1; alloc_rd = 5'd8;
    #1;
    tests++; if (alloc_tag !== 5'd1) begin fails++; $display("FAIL pair_first_tag: got %0d want 1", alloc_tag); end
    tick();
    alloc_rd = 5'd9;  tick();
    alloc_rd = 5'd10; tick();
    alloc = 1'b0;
    wb_valid1 = 1'b1; wb_tag1 = 5'd2; wb_data1 = 32'h22; tick();
    wb_tag1 = 5'd1; wb_data1 = 32'h11; tick();
    wb_valid1 = 1'b0;
    tests++; if (commit_valid1 !== 1'b0) begin fails++; $display("FAIL pair_early_commit: got %b want 0", commit_valid1); end
    tick();
    tests++; if (commit_valid1 !== 1'b1 || commit_rd1 !== 5'd8 || commit_data1 !== 32'h11 || commit_we1 !== 1'b1)
      begin fails++; $display("FAIL pair_slot1: got v=%b rd=%0d d=%h want v=1 rd=8 d=11", commit_valid1, commit_rd1, commit_data1); end
    tests++; if (commit_valid2 !== 1'b1 || commit_rd2 !== 5'd9 || commit_data2 !== 32'h22 || commit_we2 !== 1'b1)
      begin fails++; $display("FAIL pair_slot2: got v=%b rd=%0d d=%h want v=1 rd=9 d=22", commit_valid2, commit_rd2, commit_data2); end
    tests++; if (count !== 5'd1) begin fails++; $display("FAIL pair_count: got %0d want 1", count); end
    tick();
    tests++; if (commit_valid1 !== 1'b0 || commit_rd1 !== 5'd0 || commit_data1 !== 32'h0)
      begin fails++; $display("FAIL pair_pulse: got v=%b rd=%0d d=%h want all zero", commit_valid1, commit_rd1, commit_data1); end
  endtask

  task automatic test_full();
    $display("[TB] test_full");
    do_flush();
    alloc = 1'b1; alloc_we = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      alloc_rd = REG_W'(i);
      tick();
    end
    tests++; if (count !== 5'd16 || full !== 1'b1) begin fails++; $display("FAIL full_reach: got count=%0d full=%b want 16/1", count, full); end
    tick();
    tests++; if (count !== 5'd16) begin fails++; $display("FAIL full_overflow: got %0d want 16", count); end
    wb_valid1 = 1'b1; wb_tag1 = 5'd1; wb_data1 = 32'h100;
    wb_valid2 = 1'b1; wb_tag2 = 5'd2; wb_data2 = 32'h200;
    tick();
    wb_valid1 = 1'b0; wb_valid2 = 1'b0;
    tick();
    tests++; if (commit_valid1 !== 1'b1 || commit_valid2 !== 1'b1 || count !== 5'd14)
      begin fails++; $display("FAIL full_commit_no_alloc: got v=%b%b count=%0d want 11/14", commit_valid1, commit_valid2, count); end
    tests++; if (alloc_tag !== 5'd1) begin fails++; $display("FAIL full_wrap_tag1: got %0d want 1", alloc_tag); end
    tick();
    tests++; if (alloc_tag !== 5'd2) begin fails++; $display("FAIL full_wrap_tag2: got %0d want 2", alloc_tag); end
    tick();
    alloc = 1'b0;
    tests++; if (count !== 5'd16 || full !== 1'b1) begin fails++; $display("FAIL full_refill: got count=%0d full=%b want 16/1", count, full); end
  endtask

  task automatic test_lookup();
    $display("[TB] test_lookup");
    do_flush();
    alloc = 1'b1; alloc_we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      alloc_rd = REG_W'(i + 1);
      tick();
    end
    alloc = 1'b0;
    wb_valid1 = 1'b1; wb_tag1 = 5'd3; wb_data1 = 32'hDEADBEEF; tick();
    wb_valid1 = 1'b0;
    src1_tag = 5'd3; src2_tag = 5'd4;
    wb_valid2 = 1'b1; wb_tag2 = 5'd4; wb_data2 = 32'h5;
    #1;
    tests++; if (src1_ready !== 1'b1 || src1_value !== 32'hDEADBEEF) begin fails++; $display("FAIL lookup_stored: got r=%b v=%h want 1/deadbeef", src1_ready, src1_value); end
    tests++; if (src2_ready !== 1'b1 || src2_value !== 32'h5) begin fails++; $display("FAIL lookup_bypass: got r=%b v=%h want 1/5", src2_ready, src2_value); end
    src1_tag = 5'd0;
    #1;
    tests++; if (src1_ready !== 1'b0 || src1_value !== 32'h0) begin fails++; $display("FAIL lookup_null: got r=%b v=%h want 0/0", src1_ready, src1_value); end
    src1_tag = 5'd5;
    #1;
    tests++; if (src1_ready !== 1'b0) begin fails++; $display("FAIL lookup_pending: got r=%b want 0", src1_ready); end
    tick();
    wb_valid2 = 1'b0;
    #1;
    tests++; if (src2_ready !== 1'b1 || src2_value !== 32'h5) begin fails++; $display("FAIL lookup_after_wb: got r=%b v=%h want 1/5", src2_ready, src2_value); end
  endtask

  task automatic test_dual_wb();
    $display("[TB] test_dual_wb");
    wb_valid1 = 1'b1; wb_tag1 = 5'd5; wb_data1 = 32'hA;
    wb_valid2 = 1'b1; wb_tag2 = 5'd5; wb_data2 = 32'hB;
    tick();
    wb_valid1 = 1'b0; wb_valid2 = 1'b0;
    src1_tag = 5'd5;
    #1;
    tests++; if (src1_ready !== 1'b1 || src1_value !== 32'hA) begin fails++; $display("FAIL dual_wb_priority: got r=%b v=%h want 1/a", src1_ready, src1_value); end
    wb_valid1 = 1'b1; wb_tag1 = 5'd7; wb_data1 = 32'h77;
    tick();
    wb_valid1 = 1'b0;
    src1_tag = 5'd7;
    #1;
    tests++; if (src1_ready !== 1'b0) begin fails++; $display("FAIL free_wb_ready: got %b want 0", src1_ready); end
    tests++; if (commit_valid1 !== 1'b0 || count !== 5'd5) begin fails++; $display("FAIL free_wb_state: got v=%b count=%0d want 0/5", commit_valid1, count); end
  endtask

  task automatic test_flush();
    $display("[TB] test_flush");
    do_flush();
    alloc = 1'b1; alloc_we = 1'b1;
    for (int i = 0; i < 6; i++) begin alloc_rd = REG_W'(i + 20); tick(); end
    alloc = 1'b0;
    wb_valid1 = 1'b1; wb_tag1 = 5'd1; wb_data1 = 32'h1;
    wb_valid2 = 1'b1; wb_tag2 = 5'd2; wb_data2 = 32'h2;
    tick();
    wb_valid2 = 1'b0;
    flush = 1'b1; alloc = 1'b1; wb_tag1 = 5'd3; wb_data1 = 32'h3;
    tick();
    drive_idle();
    tests++; if (commit_valid1 !== 1'b0 || commit_valid2 !== 1'b0) begin fails++; $display("FAIL flush_commit: got %b%b want 00", commit_valid1, commit_valid2); end
    tests++; if (count !== 5'd0 || full !== 1'b0 || alloc_tag !== 5'd1) begin fails++; $display("FAIL flush_state: got count=%0d full=%b tag=%0d want 0/0/1", count, full, alloc_tag); end
    src1_tag = 5'd1;
    #1;
    tests++; if (src1_ready !== 1'b0) begin fails++; $display("FAIL flush_lookup: got %b want 0", src1_ready); end
    tick();
    tests++; if (commit_valid1 !== 1'b0) begin fails++; $display("FAIL flush_late_commit: got %b want 0", commit_valid1); end
    $display("[TB] test_flush reset mid-stream");
    alloc = 1'b1; alloc_we = 1'b1;
    for (int i = 0; i < 6; i++) begin alloc_rd = REG_W'(i + 24); tick(); end
    alloc = 1'b0;
    wb_valid1 = 1'b1; wb_tag1 = 5'd1; wb_data1 = 32'h41;
    wb_valid2 = 1'b1; wb_tag2 = 5'd2; wb_data2 = 32'h42;
    tick();
    drive_idle();
    tick();
    tests++; if (commit_valid1 !== 1'b1 || commit_data1 !== 32'h41) begin fails++; $display("FAIL rst_precommit: got v=%b d=%h want 1/41", commit_valid1, commit_data1); end
    #2 rst = 1'b1;
    #1;
    tests++; if (commit_valid1 !== 1'b0 || commit_valid2 !== 1'b0 || commit_data1 !== 32'h0) begin fails++; $display("FAIL rst_async_commit: got v=%b%b d=%h want 00/0", commit_valid1, commit_valid2, commit_data1); end
    tests++; if (count !== 5'd0 || alloc_tag !== 5'd1 || full !== 1'b0) begin fails++; $display("FAIL rst_async_state: got count=%0d tag=%0d full=%b want 0/1/0", count, alloc_tag, full); end
    model_clear(1'b1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic              r1, r2;
    logic [DATA_W-1:0] v1, v2;
    int                mism;
    $display("[TB] test_random");
    do_flush();
    for (int c = 0; c < 1500; c++) begin
      alloc     = ($urandom_range(0, 9) < 6);
      alloc_rd  = REG_W'($urandom);
      alloc_we  = 1'($urandom);
      flush     = ($urandom_range(0, 99) == 0);
      wb_valid1 = ($urandom_range(0, 3) != 0);
      wb_valid2 = ($urandom_range(0, 3) != 0);
      wb_data1  = $urandom;
      wb_data2  = $urandom;
      if (m_order.size() > 0 && $urandom_range(0, 7) != 0) wb_tag1 = TAG_W'(m_order[$urandom_range(0, m_order.size() - 1)]);
      else wb_tag1 = TAG_W'($urandom_range(0, 31));
      if (m_order.size() > 0 && $urandom_range(0, 7) != 0) wb_tag2 = TAG_W'(m_order[$urandom_range(0, m_order.size() - 1)]);
      else wb_tag2 = TAG_W'($urandom_range(0, 31));
      src1_tag = ($urandom_range(0, 3) == 0) ? wb_tag1 : TAG_W'($urandom_range(0, DEPTH));
      src2_tag = ($urandom_range(0, 3) == 0) ? wb_tag2 : TAG_W'($urandom_range(0, DEPTH));
      #1;
      model_src(int'(src1_tag), r1, v1);
      model_src(int'(src2_tag), r2, v2);
      tests++; if (src1_ready !== r1 || src1_value !== v1) begin fails++; $display("FAIL rnd_src1 c=%0d tag=%0d: got r=%b v=%h want r=%b v=%h", c, src1_tag, src1_ready, src1_value, r1, v1); end
      tests++; if (src2_ready !== r2 || src2_value !== v2) begin fails++; $display("FAIL rnd_src2 c=%0d tag=%0d: got r=%b v=%h want r=%b v=%h", c, src2_tag, src2_ready, src2_value, r2, v2); end
      tick();
      tests++;
      mism = 0;
      if (commit_valid1 !== e_cv1 || commit_rd1 !== e_rd1 || commit_we1 !== e_we1 || commit_data1 !== e_d1) mism++;
      if (commit_valid2 !== e_cv2 || commit_rd2 !== e_rd2 || commit_we2 !== e_we2 || commit_data2 !== e_d2) mism++;
      if (mism != 0) begin
        fails++;
        $display("FAIL rnd_commit c=%0d: got %b/%0d/%b/%h %b/%0d/%b/%h want %b/%0d/%b/%h %b/%0d/%b/%h", c,
                 commit_valid1, commit_rd1, commit_we1, commit_data1, commit_valid2, commit_rd2, commit_we2, commit_data2,
                 e_cv1, e_rd1, e_we1, e_d1, e_cv2, e_rd2, e_we2, e_d2);
      end
      tests++; if (int'(count) != m_order.size() || full !== (m_order.size() == DEPTH) || int'(alloc_tag) != m_next_tag)
        begin fails++; $display("FAIL rnd_occupancy c=%0d: got count=%0d full=%b tag=%0d want count=%0d tag=%0d", c, count, full, alloc_tag, m_order.size(), m_next_tag); end
    end
    drive_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    rst = 1'b1;
    test_reset();
    test_commit_pair();
    test_full();
    test_lookup();
    test_dual_wb();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
